// File: rtl/alu_seq.sv
// Registered EX-stage ALU with an iterative shift-add multiplier and
// restoring divider that write the architectural HI/LO registers.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_alucnt,
  input  logic [WIDTH-1:0] i_input1,
  input  logic [WIDTH-1:0] i_input2,
  input  logic [SHW-1:0]   i_shamt,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_divzero,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_SLL   = 4'd3;
  localparam logic [3:0] OP_SRL   = 4'd4;
  localparam logic [3:0] OP_SRA   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_NOR   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t r_state, w_nextState;

  logic [WIDTH-1:0] r_result, r_hi, r_lo;
  logic             r_zero, r_overflow, r_divzero, r_busy, r_done;
  logic [WIDTH-1:0] r_accHi, r_accLo, r_opB, r_rawA;
  logic [SHW:0]     r_cnt;
  logic             r_isDiv, r_negQ, r_negR, r_divZero;

  logic             w_isMulti, w_isDiv, w_signed, w_divByZero;
  logic [WIDTH-1:0] w_sum, w_diff, w_magA, w_magB;
  logic [WIDTH-1:0] w_aluResult;
  logic             w_aluOvf;
  logic [WIDTH:0]   w_mulSum, w_shifted, w_trial;
  logic [2*WIDTH-1:0] w_prod, w_prodFix;
  logic [WIDTH-1:0] w_quo, w_rem;

  assign w_isMulti   = (i_alucnt == OP_MULT) || (i_alucnt == OP_MULTU) ||
                       (i_alucnt == OP_DIV)  || (i_alucnt == OP_DIVU);
  assign w_isDiv     = (i_alucnt == OP_DIV) || (i_alucnt == OP_DIVU);
  assign w_signed    = (i_alucnt == OP_MULT) || (i_alucnt == OP_DIV);
  assign w_divByZero = w_isDiv && (i_input2 == '0);

  assign w_sum  = i_input1 + i_input2;
  assign w_diff = i_input1 - i_input2;
  assign w_magA = (w_signed && i_input1[WIDTH-1]) ? -i_input1 : i_input1;
  assign w_magB = (w_signed && i_input2[WIDTH-1]) ? -i_input2 : i_input2;

  always_comb begin
    w_aluResult = '0;
    w_aluOvf    = 1'b0;
    case (i_alucnt)
      OP_ADD: begin
        w_aluResult = w_sum;
        w_aluOvf    = (i_input1[WIDTH-1] == i_input2[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != i_input1[WIDTH-1]);
      end
      OP_SUB: begin
        w_aluResult = w_diff;
        w_aluOvf    = (i_input1[WIDTH-1] != i_input2[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != i_input1[WIDTH-1]);
      end
      OP_AND:  w_aluResult = i_input1 & i_input2;
      OP_SLL:  w_aluResult = i_input2 << i_shamt;
      OP_SRL:  w_aluResult = i_input2 >> i_shamt;
      OP_SRA:  w_aluResult = $unsigned($signed(i_input2) >>> i_shamt);
      OP_OR:   w_aluResult = i_input1 | i_input2;
      OP_XOR:  w_aluResult = i_input1 ^ i_input2;
      OP_NOR:  w_aluResult = ~(i_input1 | i_input2);
      OP_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(i_input1) < $signed(i_input2))};
      OP_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (i_input1 < i_input2)};
      default: w_aluResult = '0;
    endcase
  end

  // One iteration step: multiplier bits shift out of accLo as product bits
  // shift in; for divide, accLo holds the dividend turning into the quotient.
  assign w_mulSum  = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opB} : '0);
  assign w_shifted = {r_accHi, r_accLo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, r_opB};

  assign w_prod    = {r_accHi, r_accLo};
  assign w_prodFix = r_negQ ? -w_prod : w_prod;
  assign w_quo     = r_negQ ? -r_accLo : r_accLo;
  assign w_rem     = r_negR ? -r_accHi : r_accHi;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start && w_isMulti) w_nextState = w_divByZero ? FIN : RUN;
      RUN:     if (r_cnt == CNT_ONE) w_nextState = FIN;
      FIN:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_zero     <= 1'b1;
      r_overflow <= 1'b0;
      r_divzero  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_accHi    <= '0;
      r_accLo    <= '0;
      r_opB      <= '0;
      r_rawA     <= '0;
      r_cnt      <= '0;
      r_isDiv    <= 1'b0;
      r_negQ     <= 1'b0;
      r_negR     <= 1'b0;
      r_divZero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start && w_isMulti) begin
            r_accHi   <= '0;
            r_accLo   <= w_magA;
            r_opB     <= w_magB;
            r_rawA    <= i_input1;
            r_cnt     <= CNT_INIT;
            r_isDiv   <= w_isDiv;
            r_negQ    <= w_signed && (i_input1[WIDTH-1] ^ i_input2[WIDTH-1]);
            r_negR    <= w_signed && i_input1[WIDTH-1];
            r_divZero <= w_divByZero;
            r_busy    <= 1'b1;
          end else if (i_start) begin
            r_result   <= w_aluResult;
            r_zero     <= (w_aluResult == '0);
            r_overflow <= w_aluOvf;
            r_divzero  <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        RUN: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_isDiv) begin
            if (!w_trial[WIDTH]) begin
              r_accHi <= w_trial[WIDTH-1:0];
              r_accLo <= {r_accLo[WIDTH-2:0], 1'b1};
            end else begin
              r_accHi <= w_shifted[WIDTH-1:0];
              r_accLo <= {r_accLo[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_accHi <= w_mulSum[WIDTH:1];
            r_accLo <= {w_mulSum[0], r_accLo[WIDTH-1:1]};
          end
        end
        FIN: begin
          if (r_divZero) begin
            r_hi     <= r_rawA;
            r_lo     <= '1;
            r_result <= '1;
            r_zero   <= 1'b0;
          end else if (r_isDiv) begin
            r_hi     <= w_rem;
            r_lo     <= w_quo;
            r_result <= w_quo;
            r_zero   <= (w_quo == '0);
          end else begin
            r_hi     <= w_prodFix[2*WIDTH-1:WIDTH];
            r_lo     <= w_prodFix[WIDTH-1:0];
            r_result <= w_prodFix[WIDTH-1:0];
            r_zero   <= (w_prodFix[WIDTH-1:0] == '0);
          end
          r_overflow <= 1'b0;
          r_divzero  <= r_divZero;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_result   = r_result;
  assign o_zero     = r_zero;
  assign o_overflow = r_overflow;
  assign o_divzero  = r_divzero;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit instance for the main vectors and
// an 8-bit instance for the narrow-width multiply/divide cases.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start32 = 1'b0;
  logic [3:0]  alucnt32 = '0;
  logic [31:0] input1_32 = '0, input2_32 = '0;
  logic [4:0]  shamt32 = '0;
  logic [31:0] result32, hi32, lo32;
  logic        zero32, ovf32, dz32, busy32, done32;

  logic        start8 = 1'b0;
  logic [3:0]  alucnt8 = '0;
  logic [7:0]  input1_8 = '0, input2_8 = '0;
  logic [2:0]  shamt8 = '0;
  logic [7:0]  result8, hi8, lo8;
  logic        zero8, ovf8, dz8, busy8, done8;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_start(start32), .i_alucnt(alucnt32),
    .i_input1(input1_32), .i_input2(input2_32), .i_shamt(shamt32),
    .o_result(result32), .o_zero(zero32), .o_overflow(ovf32), .o_divzero(dz32),
    .o_busy(busy32), .o_done(done32), .o_hi(hi32), .o_lo(lo32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_alucnt(alucnt8),
    .i_input1(input1_8), .i_input2(input2_8), .i_shamt(shamt8),
    .o_result(result8), .o_zero(zero8), .o_overflow(ovf8), .o_divzero(dz8),
    .o_busy(busy8), .o_done(done8), .o_hi(hi8), .o_lo(lo8)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after acceptance.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    alucnt32  = op;
    input1_32 = a;
    input2_32 = b;
    shamt32   = sh;
    start32   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
  endtask

  // Multi-cycle op on either instance; latency is posedges after the accepting
  // edge until done is visible (done is sampled high at edge latency+1).
  task automatic runMulti(input bit use8, input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expHi, input logic [31:0] expLo,
                          input logic expDz, input int expLat, input int expBusy,
                          input bit midStart);
    int k;
    int busyCnt;
    bit seen;
    logic d, bz;
    k = 0; busyCnt = 0; seen = 0;
    if (use8) begin
      alucnt8 = op; input1_8 = a[7:0]; input2_8 = b[7:0]; start8 = 1'b1;
    end else begin
      alucnt32 = op; input1_32 = a; input2_32 = b; start32 = 1'b1;
    end
    @(posedge clk);
    while (k < 100) begin
      @(negedge clk);
      d  = use8 ? done8 : done32;
      bz = use8 ? busy8 : busy32;
      if (bz) busyCnt++;
      if (d) begin
        seen = 1;
        break;
      end
      if (midStart && k == 5) begin
        alucnt32 = 4'd0; input1_32 = 32'd1; input2_32 = 32'd1; start32 = 1'b1;
      end else begin
        start32 = 1'b0;
        start8  = 1'b0;
      end
      @(posedge clk);
      k++;
    end
    start32 = 1'b0;
    start8  = 1'b0;
    checkOutput({name, " done seen"}, 64'(seen), 64'd1);
    checkOutput({name, " latency"}, 64'(k), 64'(expLat));
    checkOutput({name, " busy cycles"}, 64'(busyCnt), 64'(expBusy));
    if (use8) begin
      checkOutput({name, " hi"}, 64'(hi8), 64'(expHi[7:0]));
      checkOutput({name, " lo"}, 64'(lo8), 64'(expLo[7:0]));
      checkOutput({name, " result"}, 64'(result8), 64'(expLo[7:0]));
      checkOutput({name, " zero"}, 64'(zero8), 64'(expLo[7:0] == 8'd0));
      checkOutput({name, " divzero"}, 64'(dz8), 64'(expDz));
      checkOutput({name, " busy at done"}, 64'(busy8), 64'd0);
    end else begin
      checkOutput({name, " hi"}, 64'(hi32), 64'(expHi));
      checkOutput({name, " lo"}, 64'(lo32), 64'(expLo));
      checkOutput({name, " result"}, 64'(result32), 64'(expLo));
      checkOutput({name, " zero"}, 64'(zero32), 64'(expLo == 32'd0));
      checkOutput({name, " divzero"}, 64'(dz32), 64'(expDz));
      checkOutput({name, " overflow"}, 64'(ovf32), 64'd0);
      checkOutput({name, " busy at done"}, 64'(busy32), 64'd0);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, " done one cycle"}, 64'(use8 ? done8 : done32), 64'd0);
  endtask

  initial begin
    int doneSeen;

    vecs[0]  = '{4'd0,  32'd2,          32'd3,          5'd0, 32'd5,          1'b0, 1'b0};
    vecs[1]  = '{4'd0,  32'h7FFF_FFFF,  32'd1,          5'd0, 32'h8000_0000,  1'b0, 1'b1};
    vecs[2]  = '{4'd1,  32'd5,          32'd5,          5'd0, 32'd0,          1'b1, 1'b0};
    vecs[3]  = '{4'd1,  32'h8000_0000,  32'd1,          5'd0, 32'h7FFF_FFFF,  1'b0, 1'b1};
    vecs[4]  = '{4'd2,  32'hF0F0_00FF,  32'h0FF0_0F0F,  5'd0, 32'h00F0_000F,  1'b0, 1'b0};
    vecs[5]  = '{4'd3,  32'hFFFF_FFFF,  32'd3,          5'd5, 32'd96,         1'b0, 1'b0};
    vecs[6]  = '{4'd4,  32'd0,          32'h8000_0000,  5'd4, 32'h0800_0000,  1'b0, 1'b0};
    vecs[7]  = '{4'd5,  32'd0,          32'h8000_0000,  5'd4, 32'hF800_0000,  1'b0, 1'b0};
    vecs[8]  = '{4'd6,  32'h1234_0000,  32'h0000_5678,  5'd0, 32'h1234_5678,  1'b0, 1'b0};
    vecs[9]  = '{4'd7,  32'hFFFF_0000,  32'h0F0F_0F0F,  5'd0, 32'hF0F0_0F0F,  1'b0, 1'b0};
    vecs[10] = '{4'd8,  32'd0,          32'd0,          5'd0, 32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[11] = '{4'd8,  32'hFFFF_0000,  32'h0000_FFFF,  5'd0, 32'd0,          1'b1, 1'b0};
    vecs[12] = '{4'd9,  32'hFFFF_FFFF,  32'd1,          5'd0, 32'd1,          1'b0, 1'b0};
    vecs[13] = '{4'd10, 32'hFFFF_FFFF,  32'd1,          5'd0, 32'd0,          1'b1, 1'b0};
    vecs[14] = '{4'd15, 32'h1234_5678,  32'h9ABC_DEF0,  5'd3, 32'd0,          1'b1, 1'b0};
    vecs[15] = '{4'd5,  32'd0,          32'h4000_0000,  5'd31, 32'd0,         1'b1, 1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset result", 64'(result32), 64'd0);
    checkOutput("reset zero", 64'(zero32), 64'd1);
    checkOutput("reset flags", 64'({ovf32, dz32, busy32, done32}), 64'd0);
    checkOutput("reset hi/lo", {hi32, lo32}, 64'd0);
    checkOutput("reset8 state", 64'({zero8, busy8, done8, hi8, lo8}), 64'h4_0000);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      checkOutput($sformatf("vec%0d done", i), 64'(done32), 64'd1);
      checkOutput($sformatf("vec%0d result", i), 64'(result32), 64'(vecs[i].res));
      checkOutput($sformatf("vec%0d zero", i), 64'(zero32), 64'(vecs[i].zero));
      checkOutput($sformatf("vec%0d overflow", i), 64'(ovf32), 64'(vecs[i].ovf));
    end
    checkOutput("single ops leave hi/lo", {hi32, lo32}, 64'd0);

    @(negedge clk);
    checkOutput("idle done low", 64'(done32), 64'd0);
    checkOutput("result holds", 64'(result32), 64'd0);

    applyStimulus(4'd0, 32'd10, 32'd20, 5'd0);
    checkOutput("b2b first result", 64'(result32), 64'd30);
    applyStimulus(4'd1, 32'd10, 32'd3, 5'd0);
    checkOutput("b2b second done", 64'(done32), 64'd1);
    checkOutput("b2b second result", 64'(result32), 64'd7);

    runMulti(0, "MULT -3*7", 4'd11, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 33, 1);
    checkOutput("ignored start result", 64'(result32), 64'hFFFF_FFEB);
    runMulti(0, "MULTU max*max", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 33, 0);
    runMulti(0, "DIV -7/2", 4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 33, 0);
    runMulti(0, "DIV 7/-2", 4'd13, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33, 33, 0);
    runMulti(0, "DIV minneg/-1", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, 33, 0);
    runMulti(0, "DIVU 100/7", 4'd14, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 33, 0);
    runMulti(0, "DIVU 100/0", 4'd14, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1, 1, 0);

    applyStimulus(4'd0, 32'd1, 32'd1, 5'd0);
    checkOutput("divzero cleared", 64'(dz32), 64'd0);
    checkOutput("hi/lo kept after ADD", {hi32, lo32}, {32'd100, 32'hFFFF_FFFF});

    alucnt32 = 4'd12; input1_32 = 32'd200; input2_32 = 32'd200; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", 64'(busy32), 64'd0);
    checkOutput("abort hi/lo", {hi32, lo32}, 64'd0);
    checkOutput("abort zero", 64'(zero32), 64'd1);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done32 || busy32) doneSeen++;
    end
    checkOutput("abort no done", 64'(doneSeen), 64'd0);

    runMulti(1, "W8 MULTU 200*200", 4'd12, 32'd200, 32'd200, 32'h9C, 32'h40, 1'b0, 9, 9, 0);
    runMulti(1, "W8 MULT -128*-128", 4'd11, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, 9, 9, 0);
    runMulti(1, "W8 DIV -128/-1", 4'd13, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, 9, 9, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Next-generation execute unit for the MIPS core: a parametrised ALU with the same `alucnt` / `input1` / `input2` / `shamt` style of operation select.
- All results are registered, and it adds an iterative multiply/divide engine with architectural HI/LO registers.
- It sits in the EX stage. Single-cycle ops complete in one clock; MULT/DIV stall the pipeline through `busy` until `done`.

Parameters:
- WIDTH, 32: datapath width in bits. Must be a power of two, ≥8.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only when busy=0.
- alucnt  in  4  operation select, captured on an accepted start.
- input1  in  WIDTH  operand A (rs), captured on an accepted start.
- input2  in  WIDTH  operand B (rt), captured on an accepted start.
- shamt  in  SHW  shift amount, captured on an accepted start.
- result  out  WIDTH  registered result.
- zero  out  1  registered; 1 when result==0.
- overflow  out  1  signed overflow for ADD/SUB.
- divzero  out  1  divide-by-zero flag for DIV/DIVU.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse: result and flags are valid.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Clock and reset:
  - One clock (clk). rst is synchronous and active-high.
  - On rst: result, hi and lo are 0; zero=1; overflow, divzero, busy and done are 0; FSM goes to IDLE.
  - rst mid-MULT/DIV aborts the operation. HI/LO are not updated with partial values and done is not pulsed.
- alucnt encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 SLL (input2<<shamt), 4 SRL, 5 SRA, 6 OR, 7 XOR, 8 NOR.
  - 9 SLT (signed, result 0/1), 10 SLTU, 11 MULT, 12 MULTU, 13 DIV, 14 DIVU.
  - 15 reserved: result=0, done pulses.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 with a single-cycle op (0–10, 15): the result is computed and registered at that edge, and done=1 in the next cycle. The FSM stays in IDLE.
  - Back-to-back starts on single-cycle ops are legal every cycle.
  - start=1 with an op in 11–14 latches the operands, loads the iteration counter with WIDTH, and moves to RUN. busy=1 from the next cycle.
- RUN:
  - One iteration per clock for exactly WIDTH clocks; the counter decrements.
  - Multiply: radix-2 shift-add on operand magnitudes.
  - Divide: restoring divide on operand magnitudes.
  - When the counter reaches 0, go to FIN.
- FIN:
  - Apply sign correction (signed variants only), write HI/LO, set result=lo, pulse done, clear busy, return to IDLE.
  - Total: done occurs WIDTH+2 edges after the accepting edge.
- start while busy=1 is ignored; the operands are not captured.
- done is high for exactly one cycle per accepted start.
- MULT/MULTU: {hi,lo} = 2·WIDTH-bit product.
  - MULT treats both operands as two's complement.
  - Product sign = sign(A) XOR sign(B).
- DIV/DIVU: lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative ÷ −1: lo = most-negative, hi = 0, no flag.
- Divide by zero (input2==0 on op 13/14):
  - Skips RUN and goes IDLE→FIN directly: done 2 edges after the accepting edge.
  - lo = all ones, hi = input1, divzero=1.
- overflow:
  - Set only for ADD/SUB when the operand signs make two's-complement overflow; the result still wraps modulo 2^WIDTH.
  - Cleared on every other completed op.
- divzero is cleared on every other completed op.
- result, zero and flags hold their values between done pulses.
- hi/lo change only at a MULT/DIV FIN.
- Shifts:
  - Only shamt is used; input1 is ignored.
  - SRA replicates input2[WIDTH-1].

Test Plan:
- Reset and ADD:
  - Stimulus: rst=1 for 2 cycles; then start with alucnt=0, input1=2, input2=3.
  - Required: done one cycle later, result=5, zero=0, overflow=0.
- Overflow and SUB:
  - ADD 0x7FFFFFFF+1 → result=0x80000000, overflow=1.
  - SUB 5−5 → result=0, zero=1.
- Shifts:
  - alucnt=3, input2=3, shamt=5 → result=96.
  - alucnt=5, input2=0x80000000, shamt=4 → result=0xF8000000.
- MULT:
  - alucnt=11, input1=−3, input2=7.
  - Required: busy for 33 cycles; done at edge 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - A start asserted mid-operation is ignored.
- DIV:
  - alucnt=13, input1=−7, input2=2 → lo=−3, hi=−1.
  - DIVU 100/0 → done after 2 edges, lo=0xFFFFFFFF, hi=100, divzero=1.
- Reset mid-op and WIDTH=8:
  - Start MULTU 200×200; assert rst on cycle 10 → busy=0, no done, hi=lo=0.
  - Rerun with WIDTH=8: MULTU 200×200 → hi=0x9C, lo=0x40, done at edge 10.
